// File: rtl/cordic_if.sv
// Operand/result handshake bundle for the iterative CORDIC sequencer.
// Optional macro: CORDIC_VECTORING_EN adds the 1-bit mode request field.
interface cordic_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] z_in;
`ifdef CORDIC_VECTORING_EN
    logic             mode;
`endif
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] y_out;
    logic [WIDTH-1:0] z_out;

    // Both directions are valid/ready: a transfer happens on a rising clk edge
    // where valid and ready are both high; valid must hold its payload until then.
`ifdef CORDIC_VECTORING_EN
    modport master (
        output start_valid, x_in, y_in, z_in, mode, res_ready,
        input  start_ready, res_valid, x_out, y_out, z_out
    );
    modport slave (
        input  start_valid, x_in, y_in, z_in, mode, res_ready,
        output start_ready, res_valid, x_out, y_out, z_out
    );
`else
    modport master (
        output start_valid, x_in, y_in, z_in, res_ready,
        input  start_ready, res_valid, x_out, y_out, z_out
    );
    modport slave (
        input  start_valid, x_in, y_in, z_in, res_ready,
        output start_ready, res_valid, x_out, y_out, z_out
    );
`endif
endinterface

// File: rtl/cordic_iter_sequencer.sv
// Iterative CORDIC engine: one micro-rotation per clock through an external atan ROM.
// Optional macro: CORDIC_VECTORING_EN adds vectoring mode (drive y toward 0).
module cordic_iter_sequencer #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    cordic_if.slave     io,
    output logic [3:0]  rom_idx,
    input  logic [15:0] rom_alpha,
    output logic        busy,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(ITER - 1);

    state_t state, state_nx;

    logic signed [WIDTH-1:0] x_r, y_r, z_r;
    logic signed [WIDTH-1:0] x_o, y_o, z_o;
    logic signed [WIDTH-1:0] x_sh, y_sh, alpha_s;
    logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;
    logic [3:0]              cnt;
    logic                    d_pos;
    logic                    start_ready_c, res_valid_c, busy_c;
    logic [3:0]              rom_idx_c;
`ifdef CORDIC_VECTORING_EN
    logic                    mode_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        start_ready_c = 1'b0;
        res_valid_c   = 1'b0;
        busy_c        = 1'b0;
        rom_idx_c     = 4'd0;
        case (state)
            S_IDLE: begin
                start_ready_c = 1'b1;
                if (io.start_valid) state_nx = S_ITER;
            end
            S_ITER: begin
                busy_c    = 1'b1;
                rom_idx_c = cnt;
                if (cnt == LAST) state_nx = S_DONE;
            end
            S_DONE: begin
                busy_c      = 1'b1;
                res_valid_c = 1'b1;
                if (io.res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Rotation steers z toward 0; vectoring steers y toward 0.
    always_comb begin
`ifdef CORDIC_VECTORING_EN
        d_pos = mode_r ? y_r[WIDTH-1] : ~z_r[WIDTH-1];
`else
        d_pos = ~z_r[WIDTH-1];
`endif
        alpha_s = WIDTH'($signed(rom_alpha));
        x_sh    = x_r >>> cnt;
        y_sh    = y_r >>> cnt;
        if (d_pos) begin
            x_nx = x_r - y_sh;
            y_nx = y_r + x_sh;
            z_nx = z_r - alpha_s;
        end else begin
            x_nx = x_r + y_sh;
            y_nx = y_r - x_sh;
            z_nx = z_r + alpha_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            cnt    <= 4'd0;
            x_o    <= '0;
            y_o    <= '0;
            z_o    <= '0;
`ifdef CORDIC_VECTORING_EN
            mode_r <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (io.start_valid) begin
                        x_r    <= io.x_in;
                        y_r    <= io.y_in;
                        z_r    <= io.z_in;
                        cnt    <= 4'd0;
`ifdef CORDIC_VECTORING_EN
                        mode_r <= io.mode;
`endif
                    end
                end
                S_ITER: begin
                    x_r <= x_nx;
                    y_r <= y_nx;
                    z_r <= z_nx;
                    if (cnt == LAST) begin
                        x_o <= x_nx;
                        y_o <= y_nx;
                        z_o <= z_nx;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.start_ready = start_ready_c;
    assign io.res_valid   = res_valid_c;
    assign io.x_out       = x_o;
    assign io.y_out       = y_o;
    assign io.z_out       = z_o;
    assign rom_idx        = rom_idx_c;
    assign busy           = busy_c;
    assign state_dbg      = state;
endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Scoreboard bench for cordic_iter_sequencer: random operations against a
// plain-arithmetic CORDIC model, plus directed angle, backpressure and reset cases.
module tb_cordic_iter_sequencer #(
    parameter int ITER = 16
);
    localparam int W = 16;

    localparam logic [15:0] ATAN [16] = '{
        16'd12868, 16'd7596, 16'd4014, 16'd2037, 16'd1023, 16'd512, 16'd256, 16'd128,
        16'd64,    16'd32,   16'd16,   16'd8,    16'd4,    16'd2,   16'd1,   16'd0
    };

    logic        clk;
    logic        rst_n;
    logic [3:0]  rom_idx;
    logic [15:0] rom_alpha;
    logic        busy;
    logic [1:0]  state_dbg;

    cordic_if #(.WIDTH(W)) ifc ();

    cordic_iter_sequencer #(.WIDTH(W), .ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (ifc.slave),
        .rom_idx   (rom_idx),
        .rom_alpha (rom_alpha),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    assign rom_alpha = ATAN[rom_idx];

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters and scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [3*W-1:0] exp_q[$];
    bit   op_active = 1'b0;
    int   acc_cyc   = 0;
    int   done_cnt  = 0;
    logic [W-1:0] lx, ly, lz;
    bit   rr_auto = 1'b1;
    bit   rr_val  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_tol(input string nm, input logic [W-1:0] act, input int ideal, input int tol);
        int a;
        a = int'($signed(act));
        total++;
        if ((a - ideal > tol) || (ideal - a > tol)) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d+-%0d", nm, a, ideal, tol);
        end
    endtask

    // Reference: plain CORDIC recurrence over integers, wrapping at W bits.
    function automatic logic [3*W-1:0] model(input logic [W-1:0] x0, input logic [W-1:0] y0,
                                             input logic [W-1:0] z0, input bit m);
        logic signed [W-1:0] x, y, z, xs, ys, a;
        bit pos;
        x = x0; y = y0; z = z0;
        for (int i = 0; i < ITER; i++) begin
            xs  = x >>> i;
            ys  = y >>> i;
            a   = $signed(ATAN[i]);
            pos = m ? (y < 0) : (z >= 0);
            if (pos) begin x = x - ys; y = y + xs; z = z - a; end
            else     begin x = x + ys; y = y - xs; z = z + a; end
        end
        return {x, y, z};
    endfunction

    // ---------------- res_ready driver ----------------
    initial begin
        ifc.res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ifc.res_ready = rr_auto ? ($urandom_range(0, 3) != 0) : rr_val;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (op_active) begin
                int k;
                k = cyc - acc_cyc;
                if (k < ITER) begin
                    chk("rom_idx_iter", 32'(rom_idx), 32'(k));
                    chk("res_valid_iter", 32'(ifc.res_valid), 32'd0);
                    chk("start_ready_iter", 32'(ifc.start_ready), 32'd0);
                    chk("busy_iter", 32'(busy), 32'd1);
                end else begin
                    if (k == ITER) chk("latency_res_valid", 32'(ifc.res_valid), 32'd1);
                    chk("rom_idx_done", 32'(rom_idx), 32'd0);
                    chk("start_ready_done", 32'(ifc.start_ready), 32'd0);
                    chk("busy_done", 32'(busy), 32'd1);
                    if (ifc.res_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", 32'd1, 32'd0);
                        end else begin
                            logic [3*W-1:0] e;
                            e = exp_q[0];
                            chk("x_out", 32'(ifc.x_out), 32'(e[3*W-1:2*W]));
                            chk("y_out", 32'(ifc.y_out), 32'(e[2*W-1:W]));
                            chk("z_out", 32'(ifc.z_out), 32'(e[W-1:0]));
                            if (ifc.res_ready) begin
                                void'(exp_q.pop_front());
                                lx = ifc.x_out;
                                ly = ifc.y_out;
                                lz = ifc.z_out;
                                op_active = 1'b0;
                                done_cnt++;
                            end
                        end
                    end
                end
            end else begin
                chk("start_ready_idle", 32'(ifc.start_ready), 32'd1);
                chk("res_valid_idle", 32'(ifc.res_valid), 32'd0);
                chk("busy_idle", 32'(busy), 32'd0);
                chk("rom_idx_idle", 32'(rom_idx), 32'd0);
                if (ifc.start_valid) begin
                    op_active = 1'b1;
                    acc_cyc   = cyc + 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] z, input bit m);
        int n;
        exp_q.push_back(model(x, y, z, m));
        @(posedge clk);
        #1;
        ifc.x_in = x;
        ifc.y_in = y;
        ifc.z_in = z;
`ifdef CORDIC_VECTORING_EN
        ifc.mode = m;
`endif
        ifc.start_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.start_ready && n < 100);
        if (!ifc.start_ready) chk("start_accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        ifc.start_valid = 1'b0;
        // Scramble operands after acceptance; they must not affect the result.
        ifc.x_in = W'($urandom);
        ifc.y_in = W'($urandom);
        ifc.z_in = W'($urandom);
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) chk("result_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] z, input bit m);
        int d0;
        d0 = done_cnt;
        issue(x, y, z, m);
        wait_done(d0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_x_out"}, 32'(ifc.x_out), 32'd0);
        chk({tag, "_y_out"}, 32'(ifc.y_out), 32'd0);
        chk({tag, "_z_out"}, 32'(ifc.z_out), 32'd0);
        chk({tag, "_res_valid"}, 32'(ifc.res_valid), 32'd0);
        chk({tag, "_start_ready"}, 32'(ifc.start_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rom_idx"}, 32'(rom_idx), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int tol, ztol, d0;
        bit m;
        tol  = (ITER >= 16) ? 4 : 64;
        ztol = (ITER >= 16) ? 4 : int'(ATAN[ITER-1]);

        rst_n = 1'b1;
        ifc.start_valid = 1'b0;
        ifc.x_in = '0;
        ifc.y_in = '0;
        ifc.z_in = '0;
`ifdef CORDIC_VECTORING_EN
        ifc.mode = 1'b0;
`endif
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        #1 rst_n = 1'b1;

        // +30 and -30 degree rotations
        run_op(16'h26DD, 16'h0000, 16'h2183, 1'b0);
        chk_tol("rot30_x", lx, 14189, tol);
        chk_tol("rot30_y", ly, 8192, tol);
        chk_tol("rot30_z", lz, 0, ztol);
        run_op(16'h26DD, 16'h0000, 16'hDE7D, 1'b0);
        chk_tol("rotm30_x", lx, 14189, tol);
        chk_tol("rotm30_y", ly, -8192, tol);
        chk_tol("rotm30_z", lz, 0, ztol);

`ifdef CORDIC_VECTORING_EN
        run_op(16'h2000, 16'h2000, 16'h0000, 1'b1);
        chk_tol("vec_x", lx, 19078, 8);
        chk_tol("vec_y", ly, 0, 4);
        chk_tol("vec_z", lz, 12868, 4);
`endif

        // randomized operations with random consumer backpressure
        for (int i = 0; i < 24; i++) begin
            m = 1'b0;
`ifdef CORDIC_VECTORING_EN
            m = 1'($urandom_range(0, 1));
`endif
            run_op(W'($urandom), W'($urandom), W'($urandom), m);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // held result with an ignored start pulse while DONE
        rr_auto = 1'b0;
        rr_val  = 1'b0;
        @(posedge clk);
        d0 = done_cnt;
        issue(W'($urandom), W'($urandom), W'($urandom), 1'b0);
        for (int n = 0; n < 100 && !ifc.res_valid; n++) @(negedge clk);
        chk("bp_res_valid_seen", 32'(ifc.res_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        ifc.x_in = W'($urandom);
        ifc.start_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.start_valid = 1'b0;
        repeat (2) @(posedge clk);
        rr_val = 1'b1;
        wait_done(d0);
        rr_val  = 1'b0;
        rr_auto = 1'b1;
        repeat (3) @(posedge clk);

        // reset in the middle of an operation
        issue(16'h1234, 16'h0567, 16'h0ABC, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_q.delete();
        op_active = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run_op(16'h26DD, 16'h0000, 16'h2183, 1'b0);
        chk_tol("post_reset_x", lx, 14189, tol);
        chk_tol("post_reset_y", ly, 8192, tol);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cordic_iter_sequencer.md
Name: cordic_iter_sequencer

Overview:
Iterative rotation-mode CORDIC engine controller. It owns the x/y/z working registers and steps the iteration index through the shared arctangent constant ROM, one micro-rotation per clock. Operands are accepted through a valid/ready input handshake and results are returned through a valid/ready output handshake. It sits between the DSP front-end issuing angle requests and the downstream sin/cos consumers.

Parameters:
WIDTH, 16, data width of x/y/z; signed two's complement, angle scale 2^14 per radian (same scale as the ROM constants).
ITER, 16, number of micro-rotations per operation; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operand request
start_ready  output  1  block can accept an operand
x_in  input  WIDTH  initial x (signed)
y_in  input  WIDTH  initial y (signed)
z_in  input  WIDTH  initial angle (signed, 2^14 scale)
rom_idx  output  4  iteration index to constant ROM
rom_alpha  input  16  arctan(2^-rom_idx) from ROM, combinational, same cycle
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
x_out  output  WIDTH  final x
y_out  output  WIDTH  final y
z_out  output  WIDTH  residual angle
busy  output  1  high in ITER or DONE

Behaviour:
- Reset (async on rst_n low): state=IDLE; x/y/z regs, iteration counter, x_out/y_out/z_out = 0; res_valid=0; busy=0; start_ready=1; rom_idx=0.
- States: IDLE, ITER, DONE.
- IDLE: start_ready=1. On start_valid, load x_in/y_in/z_in into the registers, clear the counter to 0 and go to ITER.
- ITER: start_ready=0; rom_idx=counter. Every cycle, d=+1 if z[WIDTH-1]==0 (z>=0 counts as positive), otherwise d=-1.
  - x' = x - d*(y>>>i)
  - y' = y + d*(x>>>i)
  - z' = z - d*rom_alpha
  - i = counter; >>> is arithmetic shift; all adds wrap modulo 2^WIDTH, with no saturation.
  - When counter==ITER-1, register the final values to x_out/y_out/z_out, set res_valid=1 and go to DONE. Otherwise increment the counter.
- Latency: res_valid rises exactly ITER clock edges after the edge that accepted start.
- DONE: res_valid=1. Outputs stay stable until res_valid&&res_ready. On that handshake edge, res_valid=0 and the state goes to IDLE. start_ready stays 0 in DONE, so no bypass path exists.
- Input gating: start_valid is ignored outside IDLE, and input changes during ITER have no effect.
- rom_idx is 0 whenever the state is not ITER.
- The ROM is external and is not registered. rom_alpha is sampled in the same cycle rom_idx is driven.
- Gain: no K compensation. The caller pre-scales x_in by K (0.60725 -> 0x26DD).
- Reset mid-operation returns to the reset values immediately, with no residual result.
- x_out/y_out/z_out hold their last result after the handshake until the next completion.

Optional Feature:
- Macro: CORDIC_VECTORING_EN.
- When defined, add input port mode (1 bit), sampled at start acceptance:
  - mode=0: rotation, as above.
  - mode=1: vectoring, where d=+1 if y[WIDTH-1]==1 (y<0), otherwise d=-1. Same update equations, so y is driven toward 0 and z accumulates the angle.
- When undefined, there is no mode port and the block is rotation-only.

Test Plan:
- Rotation at 30 degrees, ITER=16. Stimulus: x_in=0x26DD, y_in=0, z_in=0x2183. Required: x_out=0x376D±4, y_out=0x2000±4, |z_out|<=4, and res_valid exactly 16 cycles after acceptance.
- rom_idx sequence. Required: 0,1,...,15 on consecutive ITER cycles, and 0 in IDLE/DONE. Repeat with z_in=-0x2183 and require y_out=0xE000±4.
- Backpressure. Stimulus: hold res_ready=0 for 5 cycles after res_valid, and pulse start_valid meanwhile. Required: outputs stable, start_ready=0, the pulsed start is ignored, and the block returns to IDLE one cycle after res_ready=1.
- Reset mid-operation. Stimulus: drop rst_n at iteration 7. Required: all outputs 0 asynchronously and start_ready=1. After release, a new operation completes correctly.
- ITER=8 build. Required: res_valid 8 cycles after acceptance and rom_idx max 7. Use the 30 degree stimulus and require results within ±64 of the ideal values.
- CORDIC_VECTORING_EN. Stimulus: mode=1, x_in=0x2000, y_in=0x2000, z_in=0. Required: z_out=0x3244±4, x_out=0x4A86±8, |y_out|<=4.
